// File: rtl/bp_pkg.sv
// Shared helpers for the branch history table: counter next-state, weak-not-taken
// init value and request index hash. All operate on 32-bit containers; callers size-cast.
package bp_pkg;

    function automatic logic [31:0] wnt_val(input int unsigned cnt_w);
        return (32'd1 << (cnt_w - 1)) - 32'd1;
    endfunction

    // Saturating step: holds at the top value when taken, at zero when not taken.
    function automatic logic [31:0] sat_next(input logic [31:0] cnt, input logic taken,
                                             input int unsigned cnt_w);
        logic [31:0] top;
        top = (cnt_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cnt_w) - 32'd1);
        if (taken)
            return (cnt == top) ? cnt : cnt + 32'd1;
        else
            return (cnt == 32'd0) ? cnt : cnt - 32'd1;
    endfunction

    function automatic logic [31:0] idx_hash(input logic [31:0] pc_idx, input logic [31:0] ghr);
        return pc_idx ^ ghr;
    endfunction

endpackage

// File: rtl/bp_sat_cnt.sv
// Combinational CNT_W-bit saturating counter step; shared by the single training port.
module bp_sat_cnt
    import bp_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             taken,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             msb
);

    assign cnt_nxt = CNT_W'(sat_next(32'(cnt), taken, CNT_W));
    assign msb     = cnt[CNT_W-1];

endmodule

// File: rtl/bht_predictor.sv
// Branch history table of 2^IDX_W saturating counters with a one-cycle registered prediction.
// Define BHT_GSHARE_EN to XOR the PC index with a global history register (gshare).
module bht_predictor
    import bp_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int IDX_W = 6,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [PC_W-1:0]  req_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic             flush
);

    localparam int               ENTRIES = 1 << IDX_W;
    localparam logic [CNT_W-1:0] WNT     = CNT_W'(wnt_val(CNT_W));

    logic [CNT_W-1:0] cnt_tbl [ENTRIES];
    logic [IDX_W-1:0] pc_idx_p0;
    logic [IDX_W-1:0] req_idx_p0;
    logic [CNT_W-1:0] upd_cnt_p0;
    logic [CNT_W-1:0] upd_nxt_p0;
    logic             upd_msb_unused;
    logic             pc_unused;

    logic             vld_p1;
    logic             taken_p1;
    logic [IDX_W-1:0] idx_p1;

    // Word-aligned fetch: PC bits [1:0] never select an entry.
    assign pc_idx_p0 = req_pc[IDX_W+1:2];
    assign pc_unused = ^req_pc;

`ifdef BHT_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;

    assign req_idx_p0 = IDX_W'(idx_hash(32'(pc_idx_p0), 32'(ghr_q)));

    // Shift in resolved outcomes; a same-cycle request already saw the old history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ghr_q <= '0;
        else if (flush)
            ghr_q <= '0;
        else if (upd_valid)
            ghr_q <= IDX_W'({ghr_q, upd_taken});
    end
`else
    assign req_idx_p0 = IDX_W'(idx_hash(32'(pc_idx_p0), 32'd0));
`endif

    // ---- stage 0: training path read-modify-write ----
    assign upd_cnt_p0 = cnt_tbl[upd_idx];

    bp_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_sat (
        .cnt     (upd_cnt_p0),
        .taken   (upd_taken),
        .cnt_nxt (upd_nxt_p0),
        .msb     (upd_msb_unused)
    );

    // Flush wins over a same-cycle update; the request read below still sees pre-edge contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++)
                cnt_tbl[i] <= WNT;
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++)
                cnt_tbl[i] <= WNT;
        end else if (upd_valid) begin
            cnt_tbl[upd_idx] <= upd_nxt_p0;
        end
    end

    // ---- stage 1: registered prediction ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            taken_p1 <= 1'b0;
            idx_p1   <= '0;
        end else begin
            vld_p1 <= req_valid;
            if (req_valid) begin
                idx_p1   <= req_idx_p0;
                taken_p1 <= cnt_tbl[req_idx_p0][CNT_W-1];
            end
        end
    end

    assign pred_valid = vld_p1;
    assign pred_taken = taken_p1;
    assign pred_idx   = idx_p1;

endmodule

// File: doc/bht_predictor.md
Name: bht_predictor

Overview:
Parametrised branch history table: successor to the single 2-bit saturating-counter predictor. It holds 2^IDX_W saturating counters of CNT_W bits, indexed by fetch PC bits, and optionally by gshare XOR with a global history register. Sits beside fetch and returns a registered taken/not-taken prediction one cycle after a request. Retire/execute trains it through an update port that carries back the index issued with the prediction.

Parameters:
PC_W, 32, fetch PC width.
IDX_W, 6, table index width; the table has 2^IDX_W entries (IDX_W + 2 <= PC_W).
CNT_W, 2, saturating counter width (>= 1).

Ports:
clk  in  1  clock, all state updates on its rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  prediction request this cycle
req_pc  in  PC_W  PC of the branch being fetched
pred_valid  out  1  prediction valid, pulses one cycle after req_valid
pred_taken  out  1  predicted direction
pred_idx  out  IDX_W  table index used; caller returns it on upd_idx
upd_valid  in  1  training update this cycle
upd_idx  in  IDX_W  index to train
upd_taken  in  1  resolved branch direction
flush  in  1  synchronous: reinitialise the whole table
Reset is the asynchronous active-low input named rst_n on the single clock clk.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - every counter = WNT = 2^(CNT_W-1) - 1, the weakest not-taken value;
  - pred_valid = 0, pred_taken = 0, pred_idx = 0; GHR = 0 when enabled.
- Index: idx = req_pc[IDX_W+1:2]. PC bits [1:0] are ignored.
- Prediction, latency 1:
  - if req_valid at edge N, then at N+1: pred_valid = 1, pred_idx = idx, pred_taken = MSB of counter[idx].
  - If req_valid = 0: pred_valid = 0. pred_taken and pred_idx hold their last values.
- Update:
  - if upd_valid, counter[upd_idx] increments on upd_taken = 1 and decrements on upd_taken = 0.
  - Saturation: the counter holds at 2^CNT_W - 1 when taken and at 0 when not taken. No wrap.
- Simultaneous request and update to the same index: the prediction uses the pre-update counter value (read-before-write, no bypass). The update still commits.
- Updates to different indices in the same cycle as a request: independent.
- flush = 1:
  - all counters = WNT and GHR = 0 at the next edge;
  - an update in the same cycle is discarded;
  - a request in the same cycle still produces a prediction from the pre-flush values;
  - flush has priority over upd_valid.
- CNT_W = 1 degenerates to a last-outcome predictor, with WNT = 0.
- Reset asserted mid-stream clears everything immediately, including any in-flight prediction, so pred_valid drops asynchronously.

Optional Feature:
Macro BHT_GSHARE_EN.
- Defined:
  - IDX_W-bit global history register GHR; idx = req_pc[IDX_W+1:2] ^ GHR.
  - On each upd_valid (not flushed), GHR <= {GHR[IDX_W-2:0], upd_taken}; for IDX_W = 1, GHR <= upd_taken.
  - A request in the same cycle as a GHR shift uses the old GHR.
- Undefined: no GHR storage; idx is PC bits only.

Decomposition:
- Package bp_pkg holds:
  - the counter next-state function sat_next(cnt, taken);
  - the WNT init-value function of CNT_W;
  - the index-hash function.
- One sub-module, bp_sat_cnt: a combinational CNT_W-bit saturating next-state/MSB unit. It is instantiated once on the update path, not per entry.
- Table storage, request pipeline register and GHR stay in bht_predictor.

Test Plan:
- Reset then req_pc = 0x0000_0010 -> next cycle pred_valid = 1, pred_idx = 4, pred_taken = 0 (counter = 1).
- Three upd_taken = 1 updates to idx 4 then request PC 0x10 -> pred_taken = 1. A fourth taken update leaves the counter at 3; two not-taken updates then give pred_taken = 0 (counter 1).
- Same-cycle request and taken update to idx 4 with counter = 1 -> pred_taken = 0; the following request gives pred_taken = 1.
- Five not-taken updates to idx 7 -> counter = 0, no wrap; one taken update -> still predicts 0.
- Train idx 4 to 3, then flush with a same-cycle upd_valid -> request PC 0x10 after the flush gives pred_taken = 0. Assert rst_n low mid-request -> pred_valid = 0 immediately.
- BHT_GSHARE_EN: updates taken, taken (GHR = 6'b000011), then req_pc = 0x10 -> pred_idx = 4 ^ 3 = 7. Without the macro, pred_idx = 4.
